// File: rtl/pipeline_wb_skid_stage_pkg.sv
// Shared widths and helpers for the writeback skid stage.
package pipeline_wb_skid_stage_pkg;

  // Default datapath widths of the writeback path.
  localparam int unsigned DSIZE_DEF = 16;
  localparam int unsigned ASIZE_DEF = 3;

  // Writeback record {wen, addr, data} at the default widths.
  localparam int unsigned WB_REC_W = 1 + ASIZE_DEF + DSIZE_DEF;

  // Record width for arbitrary widths.
  function automatic int unsigned wb_rec_w(input int unsigned asize, input int unsigned dsize);
    return 1 + asize + dsize;
  endfunction

endpackage

// File: rtl/pipeline_wb_skid_stage_wb_fwd_match.sv
// One forwarding lookup: compares an address against the skid and main entries.
module pipeline_wb_skid_stage_wb_fwd_match #(
  parameter int unsigned DSIZE       = 16,
  parameter int unsigned ASIZE       = 3,
  parameter int unsigned ZERO_REG_EN = 1
) (
  input  logic [ASIZE-1:0] raddr,
  input  logic             s_valid,
  input  logic             s_wen,
  input  logic [ASIZE-1:0] s_addr,
  input  logic [DSIZE-1:0] s_data,
  input  logic             m_valid,
  input  logic             m_wen,
  input  logic [ASIZE-1:0] m_addr,
  input  logic [DSIZE-1:0] m_data,
  output logic             hit,
  output logic [DSIZE-1:0] data
);

  logic blocked;
  logic hit_s;
  logic hit_m;

  // Skid entry is younger than main, so it takes priority on a double hit.
  always_comb begin
    blocked = (ZERO_REG_EN != 0) && (raddr == '0);
    hit_s   = s_valid & s_wen & (s_addr == raddr) & ~blocked;
    hit_m   = m_valid & m_wen & (m_addr == raddr) & ~blocked;
    hit     = hit_s | hit_m;
    data    = '0;
    if (hit_s) begin
      data = s_data;
    end else if (hit_m) begin
      data = m_data;
    end
  end

endmodule

// File: rtl/pipeline_wb_skid_stage.sv
// Writeback pipeline register with a 2-entry skid buffer, flush, r0 suppression
// and forwarding lookups into the held records.
module pipeline_wb_skid_stage
  import pipeline_wb_skid_stage_pkg::*;
#(
  parameter int unsigned DSIZE       = DSIZE_DEF,
  parameter int unsigned ASIZE       = ASIZE_DEF,
  parameter int unsigned NUM_FWD     = 2,
  parameter int unsigned ZERO_REG_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_wen,
  input  logic [ASIZE-1:0]         in_addr,
  input  logic [DSIZE-1:0]         in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_wen,
  output logic [ASIZE-1:0]         out_addr,
  output logic [DSIZE-1:0]         out_data,
  input  logic [NUM_FWD*ASIZE-1:0] fwd_raddr,
  output logic [NUM_FWD-1:0]       fwd_hit,
  output logic [NUM_FWD*DSIZE-1:0] fwd_data
);

  localparam int unsigned RecW = wb_rec_w(ASIZE, DSIZE);

  // Record layout: {wen, addr, data}; stored wen is already r0-qualified.
  logic            m_valid_q, m_valid_d;
  logic [RecW-1:0] m_rec_q, m_rec_d;
  logic            s_valid_q, s_valid_d;
  logic [RecW-1:0] s_rec_q, s_rec_d;
  logic            in_ready_q, in_ready_d;

  logic            acc;
  logic            pop;
  logic            wen_eff;
  logic [RecW-1:0] in_rec;

  assign acc     = in_valid & in_ready_q;
  assign pop     = m_valid_q & out_ready;
  assign wen_eff = in_wen & ~((ZERO_REG_EN != 0) && (in_addr == '0));
  assign in_rec  = {wen_eff, in_addr, in_data};

  // Next-state for the main/skid pair; flush clears valids but keeps payloads.
  always_comb begin
    m_valid_d = m_valid_q;
    m_rec_d   = m_rec_q;
    s_valid_d = s_valid_q;
    s_rec_d   = s_rec_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || pop) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_rec_d   = s_rec_q;
        s_valid_d = acc;
        if (acc) begin
          s_rec_d = in_rec;
        end
      end else begin
        m_valid_d = acc;
        if (acc) begin
          m_rec_d = in_rec;
        end
      end
    end else if (acc) begin
      s_valid_d = 1'b1;
      s_rec_d   = in_rec;
    end
    in_ready_d = ~s_valid_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q  <= 1'b0;
      m_rec_q    <= '0;
      s_valid_q  <= 1'b0;
      s_rec_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      m_valid_q  <= m_valid_d;
      m_rec_q    <= m_rec_d;
      s_valid_q  <= s_valid_d;
      s_rec_q    <= s_rec_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Output view of the main entry; wen is masked while nothing is presented.
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = m_valid_q;
    out_wen   = m_valid_q & m_rec_q[RecW-1];
    out_addr  = m_rec_q[DSIZE +: ASIZE];
    out_data  = m_rec_q[DSIZE-1:0];
  end

  for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
    pipeline_wb_skid_stage_wb_fwd_match #(
      .DSIZE       (DSIZE),
      .ASIZE       (ASIZE),
      .ZERO_REG_EN (ZERO_REG_EN)
    ) u_match (
      .raddr   (fwd_raddr[k*ASIZE +: ASIZE]),
      .s_valid (s_valid_q),
      .s_wen   (s_rec_q[RecW-1]),
      .s_addr  (s_rec_q[DSIZE +: ASIZE]),
      .s_data  (s_rec_q[DSIZE-1:0]),
      .m_valid (m_valid_q),
      .m_wen   (m_rec_q[RecW-1]),
      .m_addr  (m_rec_q[DSIZE +: ASIZE]),
      .m_data  (m_rec_q[DSIZE-1:0]),
      .hit     (fwd_hit[k]),
      .data    (fwd_data[k*DSIZE +: DSIZE])
    );
  end

endmodule

// File: tb/tb_pipeline_wb_skid_stage.sv
// Directed table-driven bench for the writeback skid stage, plus a scoreboarded burst.
module tb_pipeline_wb_skid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [2:0]  in_addr;
  logic [15:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_wen;
  logic [2:0]  out_addr;
  logic [15:0] out_data;
  logic [5:0]  fwd_raddr;
  logic [1:0]  fwd_hit;
  logic [31:0] fwd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_wb_skid_stage #(
    .DSIZE       (16),
    .ASIZE       (3),
    .NUM_FWD     (2),
    .ZERO_REG_EN (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wen    (in_wen),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wen   (out_wen),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .fwd_raddr (fwd_raddr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic        wen;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        fl;
    logic        ordy;
    logic [5:0]  raddr;
    logic        e_ov;
    logic        e_owen;
    logic [2:0]  e_addr;
    logic [15:0] e_data;
    logic        e_irdy;
    logic [1:0]  e_hit;
    logic [31:0] e_fdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic iv, input logic wen, input logic [2:0] a,
                     input logic [15:0] d, input logic fl, input logic ordy,
                     input logic [5:0] ra, input logic ov, input logic owen,
                     input logic [2:0] ea, input logic [15:0] ed, input logic irdy,
                     input logic [1:0] hit, input logic [31:0] fd);
    vec_t v;
    v = '{r, iv, wen, a, d, fl, ordy, ra, ov, owen, ea, ed, irdy, hit, fd};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outputs(input int idx, input logic ov, input logic owen,
                             input logic [2:0] a, input logic [15:0] d, input logic irdy,
                             input logic [1:0] hit, input logic [31:0] fd);
    chk("out_valid", idx, 32'(out_valid), 32'(ov));
    chk("out_wen", idx, 32'(out_wen), 32'(owen));
    chk("out_addr", idx, 32'(out_addr), 32'(a));
    chk("out_data", idx, 32'(out_data), 32'(d));
    chk("in_ready", idx, 32'(in_ready), 32'(irdy));
    chk("fwd_hit", idx, 32'(fwd_hit), 32'(hit));
    chk("fwd_data", idx, fwd_data, fd);
  endtask

  initial begin
    logic [18:0] expq[$];
    logic [18:0] head;
    int sent;
    int recv;

    rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_addr = '0; in_data = '0;
    flush = 1'b0; out_ready = 1'b0; fwd_raddr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs(-1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 2'b00, 32'h0);

    // Fields: rst iv wen addr data fl ordy raddr{p1,p0} | ov owen addr data irdy hit fdata
    // Streaming at full rate.
    add(0, 1, 1, 3'd1, 16'h0011, 0, 1, 6'o01, 1, 1, 3'd1, 16'h0011, 1, 2'b01, 32'h0000_0011);
    add(0, 1, 1, 3'd2, 16'h0022, 0, 1, 6'o21, 1, 1, 3'd2, 16'h0022, 1, 2'b10, 32'h0022_0000);
    add(0, 1, 1, 3'd3, 16'h0033, 0, 1, 6'o33, 1, 1, 3'd3, 16'h0033, 1, 2'b11, 32'h0033_0033);
    add(0, 1, 1, 3'd4, 16'h0044, 0, 1, 6'o00, 1, 1, 3'd4, 16'h0044, 1, 2'b00, 32'h0);
    add(0, 0, 0, 3'd0, 16'h0000, 0, 1, 6'o04, 0, 0, 3'd4, 16'h0044, 1, 2'b00, 32'h0);
    // Backpressure into the skid entry, then drain on consecutive cycles.
    add(0, 1, 1, 3'd2, 16'hAAAA, 0, 0, 6'o02, 1, 1, 3'd2, 16'hAAAA, 1, 2'b01, 32'h0000_AAAA);
    add(0, 1, 1, 3'd3, 16'hBBBB, 0, 0, 6'o23, 1, 1, 3'd2, 16'hAAAA, 0, 2'b11, 32'hAAAA_BBBB);
    add(0, 1, 1, 3'd3, 16'hBBBB, 0, 0, 6'o00, 1, 1, 3'd2, 16'hAAAA, 0, 2'b00, 32'h0);
    add(0, 0, 0, 3'd0, 16'h0000, 0, 1, 6'o00, 1, 1, 3'd3, 16'hBBBB, 1, 2'b00, 32'h0);
    add(0, 0, 0, 3'd0, 16'h0000, 0, 1, 6'o03, 0, 0, 3'd3, 16'hBBBB, 1, 2'b00, 32'h0);
    // Same address in both entries: skid wins; then flush with both full.
    add(0, 1, 1, 3'd5, 16'h1234, 0, 0, 6'o65, 1, 1, 3'd5, 16'h1234, 1, 2'b01, 32'h0000_1234);
    add(0, 1, 1, 3'd5, 16'h5678, 0, 0, 6'o65, 1, 1, 3'd5, 16'h1234, 0, 2'b01, 32'h0000_5678);
    add(0, 1, 1, 3'd7, 16'hCCCC, 1, 0, 6'o05, 0, 0, 3'd5, 16'h1234, 1, 2'b00, 32'h0);
    add(0, 1, 1, 3'd6, 16'hDDDD, 1, 1, 6'o06, 0, 0, 3'd5, 16'h1234, 1, 2'b00, 32'h0);
    add(0, 0, 0, 3'd0, 16'h0000, 0, 1, 6'o06, 0, 0, 3'd5, 16'h1234, 1, 2'b00, 32'h0);
    // r0 write is suppressed and never forwarded; wen=0 never forwards.
    add(0, 1, 1, 3'd0, 16'hFFFF, 0, 1, 6'o00, 1, 0, 3'd0, 16'hFFFF, 1, 2'b00, 32'h0);
    add(0, 1, 0, 3'd6, 16'h0066, 0, 1, 6'o06, 1, 0, 3'd6, 16'h0066, 1, 2'b00, 32'h0);
    // Fill both entries, then reset mid-operation.
    add(0, 1, 1, 3'd1, 16'h0101, 0, 1, 6'o00, 1, 1, 3'd1, 16'h0101, 1, 2'b00, 32'h0);
    add(0, 1, 1, 3'd2, 16'h0202, 0, 0, 6'o12, 1, 1, 3'd1, 16'h0101, 0, 2'b11, 32'h0101_0202);
    add(1, 1, 1, 3'd3, 16'h0303, 0, 0, 6'o21, 0, 0, 3'd0, 16'h0000, 1, 2'b00, 32'h0);
    add(0, 0, 0, 3'd0, 16'h0000, 0, 1, 6'o00, 0, 0, 3'd0, 16'h0000, 1, 2'b00, 32'h0);
    add(0, 0, 0, 3'd0, 16'h0000, 0, 1, 6'o00, 0, 0, 3'd0, 16'h0000, 1, 2'b00, 32'h0);

    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      in_valid  = vecs[i].iv;
      in_wen    = vecs[i].wen;
      in_addr   = vecs[i].addr;
      in_data   = vecs[i].data;
      flush     = vecs[i].fl;
      out_ready = vecs[i].ordy;
      fwd_raddr = vecs[i].raddr;
      @(posedge clk);
      #1;
      chk_outputs(i, vecs[i].e_ov, vecs[i].e_owen, vecs[i].e_addr, vecs[i].e_data,
                  vecs[i].e_irdy, vecs[i].e_hit, vecs[i].e_fdata);
    end

    // Burst of 8 records with irregular out_ready; popped order must match accept order.
    rst = 1'b0; flush = 1'b0; fwd_raddr = '0;
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
      in_valid  = (sent < 8);
      in_wen    = 1'b1;
      in_addr   = 3'((sent % 7) + 1);
      in_data   = 16'(16'h1000 + sent);
      out_ready = ((cyc % 3) != 1);
      #1;
      if (out_valid && out_ready) begin
        head = (expq.size() > 0) ? expq.pop_front() : 19'h7FFFF;
        chk("burst_rec", recv, 32'({out_addr, out_data}), 32'(head));
        recv++;
      end
      if (in_valid && in_ready) begin
        expq.push_back({in_addr, in_data});
        sent++;
      end
      @(posedge clk);
      #1;
    end
    chk("burst_count", 0, 32'(recv), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_wb_skid_stage.md
Name: pipeline_wb_skid_stage

Overview:
- Parametrised successor to the plain writeback pipeline register.
- Carries one writeback record {wen, addr, data} from MEM to the register file through a 2-entry skid buffer with valid/ready handshake, synchronous flush and optional r0 write suppression.
- Exposes NUM_FWD forwarding lookup ports so decode/execute can bypass data still held in this stage.
- Sits between the MEM stage output and the register-file write port.

Parameters:
- DSIZE, 16: data width.
- ASIZE, 3: register address width.
- NUM_FWD, 2: number of forwarding lookup ports (>=1).
- ZERO_REG_EN, 1: when 1, address 0 is never written and never forwarded.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  upstream record valid.
- in_ready  out  1  stage can accept a record.
- in_wen  in  1  write enable of record.
- in_addr  in  ASIZE  destination register.
- in_data  in  DSIZE  write data.
- flush  in  1  discard all held records.
- out_valid  out  1  record presented to register file.
- out_ready  in  1  register file consumes record.
- out_wen  out  1  effective write enable.
- out_addr  out  ASIZE  write address.
- out_data  out  DSIZE  write data.
- fwd_raddr  in  NUM_FWD*ASIZE  packed lookup addresses; port k is bits [k*ASIZE +: ASIZE].
- fwd_hit  out  NUM_FWD  per-port match.
- fwd_data  out  NUM_FWD*DSIZE  packed forwarded data.

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high; it overrides everything else.
- Storage: main entry M (drives out_*) and skid entry S. Each entry holds {valid, wen, addr, data}.
- Reset values: M.valid=0, S.valid=0, out_valid=0, out_wen=0, out_addr=0, out_data=0, in_ready=1, fwd_hit=0.
- Handshake definitions:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready is registered and equals ~S.valid for the next cycle. The upstream must hold its record stable while in_valid=1 and in_ready=0.
- Write-enable qualification: wen_eff = in_wen & ~(ZERO_REG_EN & in_addr==0). The qualification is applied at capture; stored wen is already qualified.
- Next-state rules when flush=0:
  - M empty or pop, S empty, acc: M <= input.
  - M empty or pop, S empty, no acc: M.valid <= 0.
  - M full, no pop, acc: S <= input (in_ready then drops).
  - pop, S full: M <= S. If acc in the same cycle, S <= input; otherwise S.valid <= 0.
- Ordering is strictly FIFO; no record is dropped or duplicated.
- Latency: a record accepted in cycle N appears on out_* in cycle N+1 when the stage is empty. Throughput is 1 record/cycle with out_ready held high.
- out_addr/out_data hold their last values when out_valid=0. out_wen is forced 0 when out_valid=0.
- Flush:
  - Next cycle, M.valid=0, S.valid=0 and in_ready=1.
  - Any acc in the flush cycle is discarded.
  - A pop in the flush cycle still completes, since out_* was already presented.
- Reset mid-operation: held records are lost; the state equals the reset values next cycle.
- Forwarding (combinational from held state, no input bypass). Per port k:
  - hitS = S.valid & S.wen & S.addr==raddr_k.
  - hitM = M.valid & M.wen & M.addr==raddr_k.
  - fwd_hit[k] = hitS | hitM.
  - fwd_data_k = S.data if hitS, else M.data if hitM, else 0. S is younger and wins.
  - raddr_k==0 with ZERO_REG_EN=1 never hits.

Decomposition:
- Shared defines file: DSIZE/ASIZE defaults (existing define.v), plus a WB record width constant WB_REC_W = 1+ASIZE+DSIZE.
- One natural sub-module, wb_fwd_match: compares one lookup address against S and M, returns hit/data. Instantiate it NUM_FWD times via generate.

Test Plan:
- Reset, then stream addr=1..4, data=16'h0011..0044, wen=1, out_ready=1 -> each record appears 1 cycle after acceptance, in order; in_ready stays 1.
- out_ready=0, send addr=2/data=16'hAAAA then addr=3/data=16'hBBBB -> the second goes to skid and in_ready=0. Raise out_ready -> 16'hAAAA then 16'hBBBB pop on consecutive cycles, and in_ready returns to 1.
- With both entries full, assert flush together with in_valid -> next cycle out_valid=0 and in_ready=1; the flushed and incoming records never appear.
- ZERO_REG_EN=1, send addr=0, wen=1, data=16'hFFFF -> out_valid=1 with out_wen=0; fwd_raddr=0 gives fwd_hit=0.
- M={addr=5, 16'h1234}, S={addr=5, 16'h5678}, fwd port0 raddr=5, port1 raddr=6 -> fwd_hit=2'b01 and port0 data=16'h5678.
- Assert rst while both entries are full -> next cycle all outputs are at reset values, in_ready=1, and no stale record emerges afterwards.
